// File: rtl/arb_seq.sv
// Sequential priority arbiter: latches an N-entry priority vector, then emits entries highest
// priority first (ties to lowest index) through a pipelined compare tree, ending with an empty token.
// Optional abort port enabled by defining ARB_SEQ_ABORT_EN.
module arb_seq #(
    parameter int unsigned N         = 64,
    parameter int unsigned PW        = 3,
    parameter int unsigned REG_EVERY = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [N*PW-1:0]      in_prio_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [$clog2(N)-1:0] out_square_o,
    output logic [PW-1:0]        out_prio_o,
    output logic                 out_empty_o
`ifdef ARB_SEQ_ABORT_EN
    ,
    input  logic                 abort_i
`endif
);

    localparam int unsigned L    = $clog2(N);
    localparam int unsigned IW   = L;
    localparam int unsigned LAT  = (L + REG_EVERY - 1) / REG_EVERY;
    localparam int unsigned CntW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef logic [PW-1:0] prio_t;
    typedef logic [IW-1:0] idx_t;

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StOut
    } state_e;

    state_e            state_q, state_d;
    logic [N*PW-1:0]   vec_q, vec_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    idx_t              sq_q, sq_d;
    prio_t             pr_q, pr_d;
    logic              em_q, em_d;
    logic              abort_req;

`ifdef ARB_SEQ_ABORT_EN
    assign abort_req = abort_i;
`else
    assign abort_req = 1'b0;
`endif

    // Layer g of the tree holds N>>g nodes; a layer is registered when it closes a group of
    // REG_EVERY compare layers, except the root which lands directly in the output registers.
    function automatic logic stage_reg(input int g);
        return (g > 0) && (g < int'(L)) && ((g % int'(REG_EVERY)) == 0);
    endfunction

    prio_t tp_d [L+1][N];
    idx_t  ti_d [L+1][N];
    prio_t tp_q [L+1][N];
    idx_t  ti_q [L+1][N];
    prio_t root_prio;
    idx_t  root_idx;

    always_comb begin
        prio_t lp;
        prio_t rp;
        idx_t  li;
        idx_t  ri;
        lp = '0;
        rp = '0;
        li = '0;
        ri = '0;
        for (int g = 0; g <= int'(L); g++) begin
            for (int k = 0; k < int'(N); k++) begin
                tp_d[g][k] = '0;
                ti_d[g][k] = '0;
            end
        end
        for (int k = 0; k < int'(N); k++) begin
            tp_d[0][k] = vec_q[k*PW +: PW];
            ti_d[0][k] = idx_t'(k);
        end
        for (int g = 0; g < int'(L); g++) begin
            for (int k = 0; k < int'(N / 2); k++) begin
                if (k < int'(N >> (g + 1))) begin
                    if (stage_reg(g)) begin
                        lp = tp_q[g][2*k];
                        rp = tp_q[g][2*k+1];
                        li = ti_q[g][2*k];
                        ri = ti_q[g][2*k+1];
                    end else begin
                        lp = tp_d[g][2*k];
                        rp = tp_d[g][2*k+1];
                        li = ti_d[g][2*k];
                        ri = ti_d[g][2*k+1];
                    end
                    // Strictly greater on the right wins; equal keeps the lower index.
                    if (rp > lp) begin
                        tp_d[g+1][k] = rp;
                        ti_d[g+1][k] = ri;
                    end else begin
                        tp_d[g+1][k] = lp;
                        ti_d[g+1][k] = li;
                    end
                end
            end
        end
    end

    assign root_prio = tp_d[L][0];
    assign root_idx  = ti_d[L][0];

    // Intermediate pipeline stages carry no reset; they are only meaningful during EVAL.
    always_ff @(posedge clk_i) begin
        for (int g = 0; g <= int'(L); g++) begin
            if (stage_reg(g)) begin
                for (int k = 0; k < int'(N); k++) begin
                    tp_q[g][k] <= tp_d[g][k];
                    ti_q[g][k] <= ti_d[g][k];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        pr_d    = pr_q;
        em_d    = em_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    vec_d   = in_prio_i;
                    cnt_d   = '0;
                    state_d = StEval;
                end
            end
            StEval: begin
                if (cnt_q == CntW'(LAT - 1)) begin
                    em_d    = (root_prio == '0);
                    sq_d    = (root_prio == '0) ? '0 : root_idx;
                    pr_d    = root_prio;
                    state_d = StOut;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StOut: begin
                if (out_ready_i) begin
                    if (em_q) begin
                        state_d = StIdle;
                    end else begin
                        vec_d[sq_q*PW +: PW] = '0;
                        cnt_d                = '0;
                        state_d              = StEval;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // A concurrent handshake still counts as consumed; the sequence just ends here.
        if (abort_req && (state_q != StIdle)) begin
            state_d = StIdle;
            vec_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            vec_q   <= '0;
            cnt_q   <= '0;
            sq_q    <= '0;
            pr_q    <= '0;
            em_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            pr_q    <= pr_d;
            em_q    <= em_d;
        end
    end

    assign in_ready_o   = (state_q == StIdle);
    assign out_valid_o  = (state_q == StOut);
    assign out_square_o = sq_q;
    assign out_prio_o   = pr_q;
    assign out_empty_o  = em_q;

    hold_stable_a : assert property (@(posedge clk_i) disable iff (rst_i)
        (out_valid_o && !out_ready_i && !abort_req) |=>
        (out_valid_o && $stable(out_square_o) && $stable(out_prio_o) && $stable(out_empty_o)));

endmodule

// File: tb/tb_arb_seq.sv
// Directed bench for arb_seq (N=64, PW=3, REG_EVERY=2 -> LAT=3); abort scenario runs only
// when ARB_SEQ_ABORT_EN is defined.
module tb_arb_seq;

    localparam int N  = 64;
    localparam int PW = 3;
    localparam int IW = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N*PW-1:0] in_prio;
    logic            out_valid;
    logic            out_ready;
    logic [IW-1:0]   out_square;
    logic [PW-1:0]   out_prio;
    logic            out_empty;
`ifdef ARB_SEQ_ABORT_EN
    logic            abort;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    arb_seq #(
        .N        (N),
        .PW       (PW),
        .REG_EVERY(2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_prio_i   (in_prio),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_square_o(out_square),
        .out_prio_o  (out_prio),
        .out_empty_o (out_empty)
`ifdef ARB_SEQ_ABORT_EN
        ,
        .abort_i     (abort)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until out_valid is seen (bounded); n is the number of edges taken.
    task automatic next_out(output int n);
        n = 0;
        do begin
            tick();
            in_valid = 1'b0;
            n++;
        end while (!out_valid && n < 100);
    endtask

    function automatic logic [N*PW-1:0] vec_three();
        logic [N*PW-1:0] v;
        v = '0;
        v[5*PW +: PW]  = 3'd3;
        v[40*PW +: PW] = 3'd7;
        v[12*PW +: PW] = 3'd3;
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_prio = '0;
        tick();
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_square !== '0 || out_prio !== '0
            || out_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: rdy=%b vld=%b sq=%0d pr=%0d em=%b, required 1 0 0 0 0",
                     in_ready, out_valid, out_square, out_prio, out_empty);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_three(input string tag);
        int n;
        int exp_sq[4] = '{40, 5, 12, 0};
        int exp_pr[4] = '{7, 3, 3, 0};
        bit exp_em[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        in_prio = vec_three();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_out(n);
            vectors++;
            if (n !== 4) begin
                miscompares++;
                $display("FAIL %s spacing[%0d]: %0d cycles, required 4", tag, i, n);
            end
            vectors++;
            if (out_square !== IW'(exp_sq[i]) || out_prio !== PW'(exp_pr[i])
                || out_empty !== exp_em[i]) begin
                miscompares++;
                $display("FAIL %s result[%0d]: (%0d,%0d,em=%b), required (%0d,%0d,em=%b)", tag, i,
                         out_square, out_prio, out_empty, exp_sq[i], exp_pr[i], exp_em[i]);
            end
        end
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle: rdy=%b vld=%b, required 1 0", tag, in_ready, out_valid);
        end
    endtask

    task automatic test_all_zero();
        int n;
        out_ready = 1'b1;
        in_prio = '0;
        in_valid = 1'b1;
        next_out(n);
        vectors++;
        if (n !== 4 || out_empty !== 1'b1 || out_square !== '0 || out_prio !== '0) begin
            miscompares++;
            $display("FAIL zero_load: n=%0d em=%b sq=%0d pr=%0d, required 4 1 0 0",
                     n, out_empty, out_square, out_prio);
        end
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_idle: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_all_seven();
        int n;
        out_ready = 1'b1;
        in_prio = '1;
        in_valid = 1'b1;
        for (int i = 0; i < 65; i++) begin
            next_out(n);
            vectors++;
            if (i < 64) begin
                if (n !== 4 || out_square !== IW'(i) || out_prio !== 3'd7 || out_empty !== 1'b0)
                begin
                    miscompares++;
                    $display("FAIL all7[%0d]: n=%0d (%0d,%0d,em=%b), required 4 (%0d,7,em=0)",
                             i, n, out_square, out_prio, out_empty, i);
                end
            end else begin
                if (n !== 4 || out_empty !== 1'b1 || out_square !== '0 || out_prio !== '0) begin
                    miscompares++;
                    $display("FAIL all7_empty: n=%0d (%0d,%0d,em=%b), required 4 (0,0,em=1)",
                             n, out_square, out_prio, out_empty);
                end
            end
        end
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL all7_idle: rdy=%b, required 1", in_ready);
        end
    endtask

    task automatic test_hold();
        int n;
        logic [N*PW-1:0] v;
        v = '0;
        v[63*PW +: PW] = 3'd1;
        out_ready = 1'b0;
        in_prio = v;
        in_valid = 1'b1;
        next_out(n);
        vectors++;
        if (n !== 4 || out_square !== 6'd63 || out_prio !== 3'd1 || out_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_first: n=%0d (%0d,%0d,em=%b), required 4 (63,1,em=0)",
                     n, out_square, out_prio, out_empty);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = (c % 3 == 0);
            in_prio = '1;
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_square !== 6'd63 || out_prio !== 3'd1
                || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hold[%0d]: vld=%b (%0d,%0d) rdy=%b, required 1 (63,1) 0",
                         c, out_valid, out_square, out_prio, in_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        next_out(n);
        vectors++;
        if (n !== 4 || out_empty !== 1'b1 || out_square !== '0 || out_prio !== '0) begin
            miscompares++;
            $display("FAIL hold_empty: n=%0d (%0d,%0d,em=%b), required 4 (0,0,em=1)",
                     n, out_square, out_prio, out_empty);
        end
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_idle: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_rst_mid();
        int n;
        out_ready = 1'b1;
        in_prio = vec_three();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_eval: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
        in_valid = 1'b1;
        next_out(n);
        out_ready = 1'b0;
        vectors++;
        if (n !== 4 || out_square !== 6'd40 || out_prio !== 3'd7) begin
            miscompares++;
            $display("FAIL rst_reload: n=%0d (%0d,%0d), required 4 (40,7)", n, out_square, out_prio);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_square !== '0 || out_prio !== '0
            || out_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_out: vld=%b rdy=%b (%0d,%0d,em=%b), required 0 1 (0,0,em=0)",
                     out_valid, in_ready, out_square, out_prio, out_empty);
        end
        test_three("rst_after");
    endtask

`ifdef ARB_SEQ_ABORT_EN
    task automatic test_abort();
        int n;
        out_ready = 1'b1;
        in_prio = vec_three();
        in_valid = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        next_out(n);
        vectors++;
        if (n !== 3 || out_square !== 6'd40 || out_prio !== 3'd7) begin
            miscompares++;
            $display("FAIL abort_idle: n=%0d (%0d,%0d), required 3 (40,7)", n, out_square, out_prio);
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_eval: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_quiet[%0d]: vld=%b, required 0", c, out_valid);
            end
        end
        test_three("abort_after");
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_prio = '0;
`ifdef ARB_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_three("three");
        test_all_zero();
        test_all_seven();
        test_hold();
        test_rst_mid();
`ifdef ARB_SEQ_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
